wb_ddr_arbiter: RTL and testbench

//  Round-robin Wishbone arbiter that shares the single DDR controller slave port

---
 rtl/wb_ddr_arbiter_if.sv | 26 ++
 rtl/wb_ddr_arbiter.sv | 100 ++++++++++
 tb/tb_wb_ddr_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ddr_arbiter_if.sv
// Wishbone bundle joining NUM_MASTERS bus masters, the round-robin arbiter and the
// single DDR controller slave port. Master vectors are packed, master i in row i.
interface wb_ddr_arbiter_if #(
  parameter int NUM_MASTERS = 3
);
  logic [NUM_MASTERS-1:0]       m_cyc, m_stb, m_we;
  logic [NUM_MASTERS-1:0][31:0] m_adr, m_dat_w;
  logic [NUM_MASTERS-1:0][3:0]  m_sel;
  logic [31:0]                  m_dat_r;
  logic [NUM_MASTERS-1:0]       m_ack, m_err, grant;
  logic                         s_cyc, s_stb, s_we, s_ack;
  logic [31:0]                  s_adr, s_dat_w, s_dat_r;
  logic [3:0]                   s_sel;

  // arbiter view: slave towards the masters, master towards the DDR controller
  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_w, s_dat_r, s_ack,
    output m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w, grant
  );

  // environment view: the bus masters plus the DDR controller
  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_w, s_dat_r, s_ack,
    input  m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w, grant
  );
endinterface

// File: rtl/wb_ddr_arbiter.sv
// Round-robin Wishbone arbiter in front of the DDR controller. Grant is held for the
// whole m_cyc cycle; a watchdog turns a stalled strobe into a one-cycle m_err.
module wb_ddr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  wb_ddr_arbiter_if.slave bus
);
  localparam int          LW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [15:0] WD_LIM = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'hffff;

  typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q;
  logic [15:0]            wd_q, wd_d;

  logic [LW-1:0]          g_idx, pick_idx;
  logic                   pick_vld, own, g_cyc, wd_hit;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_q[i]) g_idx = LW'(i);
  end

  // Search last+N down to last+1 so the nearest requester after `last` is written last.
  always_comb begin
    logic [LW-1:0] cand;
    cand     = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = LW'((int'(last_q) + k) % NUM_MASTERS);
      if (bus.m_cyc[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    grant_d           = '0;
    grant_d[pick_idx] = pick_vld;
  end

  assign own   = (state_q == OWN);
  assign g_cyc = bus.m_cyc[g_idx];

  // In IDLE g_idx is 0, so the address/data mux shows master 0.
  assign bus.s_cyc   = (state_q != IDLE);
  assign bus.s_stb   = own & bus.m_stb[g_idx];
  assign bus.s_we    = bus.m_we[g_idx];
  assign bus.s_adr   = bus.m_adr[g_idx];
  assign bus.s_sel   = bus.m_sel[g_idx];
  assign bus.s_dat_w = bus.m_dat_w[g_idx];
  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.grant   = grant_q;

  assign wd_hit = (TIMEOUT > 0) && bus.s_stb && !bus.s_ack && (wd_q == WD_LIM);

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    assign bus.m_ack[i] = grant_q[i] & own & bus.s_ack;
    assign bus.m_err[i] = grant_q[i] & wd_hit;
  end

  // Counts consecutive stalled strobe cycles; anything else, including leaving OWN, clears it.
  always_comb begin
    wd_d = '0;
    if (own && g_cyc && !wd_hit && bus.s_stb && !bus.s_ack)
      wd_d = (wd_q == 16'hffff) ? wd_q : wd_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      wd_q <= wd_d;
      case (state_q)
        IDLE:
          if (pick_vld) begin
            grant_q <= grant_d;
            state_q <= OWN;
          end
        OWN, ERR:
          if (!g_cyc) begin
            last_q  <= g_idx;
            grant_q <= '0;
            state_q <= IDLE;
          end else if (wd_hit) begin
            state_q <= ERR;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// Bench for wb_ddr_arbiter: per-cycle vector table, directed corner sequences and a
// randomized run against a rule-level ownership model.
module tb_wb_ddr_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wb_ddr_arbiter_if #(.NUM_MASTERS(N)) bus  ();
  wb_ddr_arbiter_if #(.NUM_MASTERS(N)) bus0 ();

  wb_ddr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  wb_ddr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(0))  dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] cyc, stb;
    logic         ack;
    logic [N-1:0] g;
    logic         scyc, sstb;
    logic [N-1:0] mack;
  } vec_t;
  vec_t vq[$];

  logic [31:0] adr_tab [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic ack);
    bus.m_cyc = cyc;
    bus.m_stb = stb;
    bus.s_ack = ack;
  endtask

  task automatic add(input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic ack,
                     input logic [N-1:0] g, input logic scyc, input logic sstb,
                     input logic [N-1:0] mack);
    vq.push_back('{cyc, stb, ack, g, scyc, sstb, mack});
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // rule-level model state: owner -1 means nobody holds the slave
  int   owner, last, waited;
  bit   in_err;

  initial begin
    logic [31:0]  d;
    int           nerr;
    int           cyc_div, ack_div;
    logic [N-1:0] e_grant, e_ack, e_err;
    logic         e_stb, found;

    adr_tab[0] = 32'h4000_0010;
    adr_tab[1] = 32'h4000_0120;
    adr_tab[2] = 32'h4000_0230;
    for (int i = 0; i < N; i++) begin
      bus.m_adr[i]   = adr_tab[i];
      bus.m_dat_w[i] = 32'hd000_0000 + i;
      bus.m_sel[i]   = 4'hf;
      bus0.m_adr[i]  = adr_tab[i];
      bus0.m_dat_w[i] = '0;
      bus0.m_sel[i]  = 4'hf;
    end
    bus.m_we  = '0;  bus.s_dat_r  = '0;
    bus0.m_we = '0;  bus0.s_dat_r = '0;
    bus0.m_cyc = '0; bus0.m_stb = '0; bus0.s_ack = 1'b0;

    // reset state with requests and a stray ack present
    reset_n = 1'b0;
    drv(3'b111, 3'b111, 1'b1);
    tick(); #1;
    chk("rst_grant", bus.grant, 3'b000);
    chk("rst_scyc",  bus.s_cyc, 1'b0);
    chk("rst_sstb",  bus.s_stb, 1'b0);
    chk("rst_mack",  bus.m_ack, 3'b000);
    chk("rst_merr",  bus.m_err, 3'b000);
    drv(3'b000, 3'b000, 1'b0);
    tick(); reset_n = 1'b1;

    // single read by m0, then m1, m2, m0 back to back
    add(3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000);
    add(3'b001, 3'b001, 0, 3'b000, 0, 0, 3'b000);
    add(3'b001, 3'b001, 0, 3'b001, 1, 1, 3'b000);
    add(3'b001, 3'b001, 0, 3'b001, 1, 1, 3'b000);
    add(3'b001, 3'b001, 0, 3'b001, 1, 1, 3'b000);
    add(3'b001, 3'b001, 1, 3'b001, 1, 1, 3'b001);
    add(3'b110, 3'b110, 0, 3'b001, 1, 0, 3'b000);
    add(3'b110, 3'b110, 0, 3'b000, 0, 0, 3'b000);
    add(3'b110, 3'b110, 1, 3'b010, 1, 1, 3'b010);
    add(3'b101, 3'b101, 0, 3'b010, 1, 0, 3'b000);
    add(3'b101, 3'b101, 0, 3'b000, 0, 0, 3'b000);
    add(3'b101, 3'b101, 1, 3'b100, 1, 1, 3'b100);
    add(3'b001, 3'b001, 0, 3'b100, 1, 0, 3'b000);
    add(3'b001, 3'b001, 0, 3'b000, 0, 0, 3'b000);
    add(3'b001, 3'b001, 1, 3'b001, 1, 1, 3'b001);
    add(3'b000, 3'b000, 0, 3'b001, 1, 0, 3'b000);
    add(3'b000, 3'b000, 0, 3'b000, 0, 0, 3'b000);

    for (int r = 0; r < vq.size(); r++) begin
      tick();
      drv(vq[r].cyc, vq[r].stb, vq[r].ack);
      d = $urandom;
      bus.s_dat_r = d;
      #1;
      chk($sformatf("tbl%0d_grant", r), bus.grant, vq[r].g);
      chk($sformatf("tbl%0d_scyc", r),  bus.s_cyc, vq[r].scyc);
      chk($sformatf("tbl%0d_sstb", r),  bus.s_stb, vq[r].sstb);
      chk($sformatf("tbl%0d_mack", r),  bus.m_ack, vq[r].mack);
      chk($sformatf("tbl%0d_merr", r),  bus.m_err, 3'b000);
      chk($sformatf("tbl%0d_sadr", r),  bus.s_adr, adr_tab[oh2i(vq[r].g)]);
      chk($sformatf("tbl%0d_mdat", r),  bus.m_dat_r, d);
    end

    // m1 holds the bus over 4 writes while m0 and m2 wait (last=0 here)
    tick(); drv(3'b111, 3'b111, 1'b0); bus.m_we = 3'b010; #1;
    chk("own_idle_grant", bus.grant, 3'b000);
    for (int b = 0; b < 4; b++) begin
      tick(); bus.m_adr[1] = 32'h4000_1000 + 32'(b * 4); bus.s_ack = 1'b1; #1;
      chk($sformatf("own_b%0d_grant", b), bus.grant, 3'b010);
      chk($sformatf("own_b%0d_sadr", b),  bus.s_adr, 32'h4000_1000 + 32'(b * 4));
      chk($sformatf("own_b%0d_swe", b),   bus.s_we, 1'b1);
      chk($sformatf("own_b%0d_mack", b),  bus.m_ack, 3'b010);
    end
    tick(); drv(3'b101, 3'b101, 1'b0); bus.m_we = '0; #1;
    chk("own_rel_grant", bus.grant, 3'b010);
    tick(); #1;
    chk("own_gap_scyc", bus.s_cyc, 1'b0);
    tick(); bus.s_ack = 1'b1; #1;
    chk("own_m2_grant", bus.grant, 3'b100);
    chk("own_m2_sadr",  bus.s_adr, adr_tab[2]);
    chk("own_m2_mack",  bus.m_ack, 3'b100);
    tick(); drv(3'b001, 3'b001, 1'b0);
    tick(); #1;
    chk("own_gap2_grant", bus.grant, 3'b000);
    tick(); bus.s_ack = 1'b1; #1;
    chk("own_m0_grant", bus.grant, 3'b001);
    chk("own_m0_mack",  bus.m_ack, 3'b001);
    tick(); drv(3'b000, 3'b000, 1'b0);
    tick(); #1;
    chk("own_end_grant", bus.grant, 3'b000);

    // watchdog: m1 stalls with no ack (last=0 so m1 wins)
    tick(); drv(3'b010, 3'b010, 1'b0);
    for (int n = 1; n <= TO; n++) begin
      tick(); #1;
      chk($sformatf("wd_n%0d_sstb", n), bus.s_stb, 1'b1);
      chk($sformatf("wd_n%0d_mack", n), bus.m_ack, 3'b000);
      chk($sformatf("wd_n%0d_merr", n), bus.m_err, (n == TO) ? 3'b010 : 3'b000);
    end
    tick(); bus.s_ack = 1'b1; #1;
    chk("wd_err_sstb",  bus.s_stb, 1'b0);
    chk("wd_err_scyc",  bus.s_cyc, 1'b1);
    chk("wd_err_grant", bus.grant, 3'b010);
    chk("wd_err_mack",  bus.m_ack, 3'b000);
    chk("wd_err_merr",  bus.m_err, 3'b000);
    tick(); drv(3'b000, 3'b000, 1'b0); #1;
    chk("wd_rel_grant", bus.grant, 3'b010);
    tick(); #1;
    chk("wd_idle_grant", bus.grant, 3'b000);
    chk("wd_idle_scyc",  bus.s_cyc, 1'b0);

    // watchdog disabled: 1000 stalled cycles, then a normal ack
    tick(); bus0.m_cyc = 3'b001; bus0.m_stb = 3'b001;
    nerr = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(); #1;
      if (bus0.m_err != 3'b000) nerr++;
    end
    chk("t0_no_err", 64'(nerr), 64'd0);
    chk("t0_grant",  bus0.grant, 3'b001);
    bus0.s_ack = 1'b1; #1;
    chk("t0_mack", bus0.m_ack, 3'b001);
    tick(); bus0.m_cyc = '0; bus0.m_stb = '0; bus0.s_ack = 1'b0;

    // async reset during an m2 strobe (last=1 so m2 wins), m0 pending
    tick(); drv(3'b100, 3'b100, 1'b0);
    tick(); #1;
    chk("ar_grant_pre", bus.grant, 3'b100);
    tick(); drv(3'b101, 3'b101, 1'b1); reset_n = 1'b0; #1;
    chk("ar_grant", bus.grant, 3'b000);
    chk("ar_scyc",  bus.s_cyc, 1'b0);
    chk("ar_mack",  bus.m_ack, 3'b000);
    tick(); reset_n = 1'b1; bus.s_ack = 1'b0; #1;
    chk("ar_post_grant", bus.grant, 3'b000);
    tick(); #1;
    chk("ar_m0_wins", bus.grant, 3'b001);
    tick(); drv(3'b000, 3'b000, 1'b0);

    // randomized traffic against the ownership model, from a fresh reset
    tick(); reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    owner = -1; last = N - 1; waited = 0; in_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cyc_div = (c < 1500) ? 7 : 31;
      ack_div = (c < 1500) ? 11 : 40;
      tick();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(cyc_div) == 0) bus.m_cyc[i] = ~bus.m_cyc[i];
        bus.m_stb[i]   = ($urandom_range(3) != 0);
        bus.m_we[i]    = $urandom_range(1);
        bus.m_adr[i]   = $urandom;
        bus.m_dat_w[i] = $urandom;
        bus.m_sel[i]   = 4'($urandom);
      end
      bus.s_ack   = ($urandom_range(ack_div) == 0);
      d           = $urandom;
      bus.s_dat_r = d;
      #1;
      e_grant = (owner >= 0) ? (N'(1) << owner) : '0;
      e_stb   = (owner >= 0) && !in_err && bus.m_stb[owner];
      e_ack   = ((owner >= 0) && !in_err && bus.s_ack) ? e_grant : '0;
      e_err   = (e_stb && !bus.s_ack && waited == TO - 1) ? e_grant : '0;
      chk($sformatf("rnd%0d_grant", c), bus.grant, e_grant);
      chk($sformatf("rnd%0d_scyc", c),  bus.s_cyc, owner >= 0);
      chk($sformatf("rnd%0d_sstb", c),  bus.s_stb, e_stb);
      chk($sformatf("rnd%0d_mack", c),  bus.m_ack, e_ack);
      chk($sformatf("rnd%0d_merr", c),  bus.m_err, e_err);
      chk($sformatf("rnd%0d_sadr", c),  bus.s_adr, bus.m_adr[(owner >= 0) ? owner : 0]);
      chk($sformatf("rnd%0d_mdat", c),  bus.m_dat_r, d);
      // ownership rules applied at the coming edge
      if (owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++)
          if (!found && bus.m_cyc[(last + k) % N]) begin
            owner = (last + k) % N;
            found = 1'b1;
          end
      end else if (!bus.m_cyc[owner]) begin
        last = owner; owner = -1; in_err = 1'b0; waited = 0;
      end else if (e_err != '0) begin
        in_err = 1'b1; waited = 0;
      end else if (!in_err) begin
        waited = (bus.m_stb[owner] && !bus.s_ack) ? waited + 1 : 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
